// File: rtl/gemm_pkg.sv
// Shared types and helpers for the streaming GEMM engine: FSM encoding,
// default geometry, index-width helper and the result saturation function.
package gemm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        LOAD_C,
        MAC,
        SCALE,
        OUT
    } state_t;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_FRAC_BITS  = 8;
    localparam int DEF_DIM_M      = 4;
    localparam int DEF_DIM_N      = 4;
    localparam int DEF_DIM_K      = 4;
    localparam int DEF_ACC_WIDTH  = 40;

    // Wide enough for any legal ACC_WIDTH + DATA_WIDTH + 1 intermediate sum
    localparam int SAT_W = 128;

    function automatic int idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Clamp x to the signed range of a dw-bit word, returned sign-extended
    function automatic logic signed [SAT_W-1:0] sat_to_data(
        input logic signed [SAT_W-1:0] x,
        input int                      dw
    );
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (SAT_W'(1) <<< (dw - 1)) - SAT_W'(1);
        lo = -hi - SAT_W'(1);
        if (x > hi) begin
            return hi;
        end
        if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

endpackage

// File: rtl/gemm_stream_engine_if.sv
// Operand input stream and result output stream of the GEMM engine.
// The engine uses the slave view; the producer/consumer uses master.
interface gemm_stream_engine_if #(
    parameter int DATA_WIDTH = gemm_pkg::DEF_DATA_WIDTH
);
    logic                         in_valid;
    logic                         in_ready;
    logic signed [DATA_WIDTH-1:0] in_data;
    logic                         out_valid;
    logic                         out_ready;
    logic signed [DATA_WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/gemm_mac.sv
// Signed multiply-accumulate: full-width product sign-extended into the
// accumulator; clr restarts the sum with the current product.
module gemm_mac #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 40
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr,
    input  logic                         en,
    input  logic signed [DATA_WIDTH-1:0] a,
    input  logic signed [DATA_WIDTH-1:0] b,
    output logic signed [ACC_WIDTH-1:0]  acc
);
    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0]    prod_ext;
    logic signed [ACC_WIDTH-1:0]    acc_reg;

    assign prod     = a * b;
    assign prod_ext = ACC_WIDTH'(prod);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_reg <= '0;
        end else if (en) begin
            acc_reg <= clr ? prod_ext : acc_reg + prod_ext;
        end
    end

    assign acc = acc_reg;
endmodule

// File: rtl/gemm_stream_engine.sv
// Streaming fixed-point GEMM: R = alpha*(A x B) + beta*C, operands loaded
// row-major A, B, C over one stream, one MAC per cycle, results streamed out.
module gemm_stream_engine
    import gemm_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FRAC_BITS  = DEF_FRAC_BITS,
    parameter int DIM_M      = DEF_DIM_M,
    parameter int DIM_N      = DEF_DIM_N,
    parameter int DIM_K      = DEF_DIM_K,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH
) (
    input  logic                         iclk,
    input  logic                         irst_n,
    input  logic                         istart,
    input  logic signed [DATA_WIDTH-1:0] alpha,
    input  logic signed [DATA_WIDTH-1:0] beta,
    gemm_stream_engine_if.slave          bus,
    output logic                         obusy,
    output logic                         odone,
    output logic                         osat
);
    localparam int A_DEPTH = DIM_M * DIM_K;
    localparam int B_DEPTH = DIM_K * DIM_N;
    localparam int C_DEPTH = DIM_M * DIM_N;
    localparam int A_AW    = idx_w(A_DEPTH);
    localparam int B_AW    = idx_w(B_DEPTH);
    localparam int C_AW    = idx_w(C_DEPTH);
    localparam int LD_W    = idx_w(max3(A_DEPTH, B_DEPTH, C_DEPTH));
    localparam int I_W     = idx_w(DIM_M);
    localparam int J_W     = idx_w(DIM_N);
    localparam int K_W     = idx_w(DIM_K);
    localparam int SUM_W   = ACC_WIDTH + DATA_WIDTH + 1;

    state_t state_reg, state_next;
    logic [LD_W-1:0] ld_cnt_reg;
    logic [I_W-1:0]  i_reg;
    logic [J_W-1:0]  j_reg;
    logic [K_W-1:0]  k_reg;
    logic signed [DATA_WIDTH-1:0] alpha_reg, beta_reg, out_data_reg;
    logic out_valid_reg, obusy_reg, odone_reg, osat_reg;

    logic signed [DATA_WIDTH-1:0] a_mem [A_DEPTH];
    logic signed [DATA_WIDTH-1:0] b_mem [B_DEPTH];
    logic signed [DATA_WIDTH-1:0] c_mem [C_DEPTH];

    logic in_ready, ld_end, in_fire, out_fire, k_last, elem_last, start_ok;
    logic signed [DATA_WIDTH-1:0] a_op, b_op, c_op;
    logic signed [ACC_WIDTH-1:0]  acc, dot;
    logic signed [SUM_W-1:0]      t1, t2, sum;
    logic signed [SAT_W-1:0]      sum_ext, sat_val;
    logic                         sat_hit;

    assign in_fire   = in_ready && bus.in_valid;
    assign out_fire  = (state_reg == OUT) && bus.out_ready;
    assign k_last    = (k_reg == K_W'(DIM_K - 1));
    assign elem_last = (i_reg == I_W'(DIM_M - 1)) && (j_reg == J_W'(DIM_N - 1));
    assign start_ok  = (state_reg == IDLE) && istart;

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        ld_end     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (istart) state_next = LOAD_A;
            end
            LOAD_A: begin
                in_ready = 1'b1;
                ld_end   = (ld_cnt_reg == LD_W'(A_DEPTH - 1));
                if (bus.in_valid && ld_end) state_next = LOAD_B;
            end
            LOAD_B: begin
                in_ready = 1'b1;
                ld_end   = (ld_cnt_reg == LD_W'(B_DEPTH - 1));
                if (bus.in_valid && ld_end) state_next = LOAD_C;
            end
            LOAD_C: begin
                in_ready = 1'b1;
                ld_end   = (ld_cnt_reg == LD_W'(C_DEPTH - 1));
                if (bus.in_valid && ld_end) state_next = MAC;
            end
            MAC: begin
                if (k_last) state_next = SCALE;
            end
            SCALE: begin
                state_next = OUT;
            end
            OUT: begin
                if (bus.out_ready) state_next = elem_last ? IDLE : MAC;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand buffers carry no reset; they are always reloaded before use
    always_ff @(posedge iclk) begin
        if (irst_n && in_fire) begin
            case (state_reg)
                LOAD_A:  a_mem[A_AW'(ld_cnt_reg)] <= bus.in_data;
                LOAD_B:  b_mem[B_AW'(ld_cnt_reg)] <= bus.in_data;
                LOAD_C:  c_mem[C_AW'(ld_cnt_reg)] <= bus.in_data;
                default: ;
            endcase
        end
    end

    assign a_op = a_mem[A_AW'(int'(i_reg) * DIM_K + int'(k_reg))];
    assign b_op = b_mem[B_AW'(int'(k_reg) * DIM_N + int'(j_reg))];
    assign c_op = c_mem[C_AW'(int'(i_reg) * DIM_N + int'(j_reg))];

    gemm_mac #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_mac (
        .clk   (iclk),
        .rst_n (irst_n),
        .clr   (k_reg == '0),
        .en    (state_reg == MAC),
        .a     (a_op),
        .b     (b_op),
        .acc   (acc)
    );

    // Scale stage: every shift is arithmetic, i.e. truncation toward -inf
    assign dot     = acc >>> FRAC_BITS;
    assign t1      = (SUM_W'(alpha_reg) * SUM_W'(dot)) >>> FRAC_BITS;
    assign t2      = (SUM_W'(beta_reg) * SUM_W'(c_op)) >>> FRAC_BITS;
    assign sum     = t1 + t2;
    assign sum_ext = SAT_W'(sum);
    assign sat_val = sat_to_data(sum_ext, DATA_WIDTH);
    assign sat_hit = (sat_val != sum_ext);

    always_ff @(posedge iclk) begin
        if (!irst_n) begin
            state_reg     <= IDLE;
            ld_cnt_reg    <= '0;
            i_reg         <= '0;
            j_reg         <= '0;
            k_reg         <= '0;
            alpha_reg     <= '0;
            beta_reg      <= '0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
            obusy_reg     <= 1'b0;
            odone_reg     <= 1'b0;
            osat_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            odone_reg <= 1'b0;
            if (start_ok) begin
                alpha_reg  <= alpha;
                beta_reg   <= beta;
                obusy_reg  <= 1'b1;
                osat_reg   <= 1'b0;
                ld_cnt_reg <= '0;
                i_reg      <= '0;
                j_reg      <= '0;
                k_reg      <= '0;
            end
            if (in_fire) begin
                ld_cnt_reg <= ld_end ? '0 : ld_cnt_reg + LD_W'(1);
            end
            if (state_reg == MAC) begin
                k_reg <= k_last ? '0 : k_reg + K_W'(1);
            end
            if (state_reg == SCALE) begin
                out_data_reg  <= sat_val[DATA_WIDTH-1:0];
                out_valid_reg <= 1'b1;
                if (sat_hit) osat_reg <= 1'b1;
            end
            if (out_fire) begin
                out_valid_reg <= 1'b0;
                if (elem_last) begin
                    obusy_reg <= 1'b0;
                    odone_reg <= 1'b1;
                    i_reg     <= '0;
                    j_reg     <= '0;
                end else if (j_reg == J_W'(DIM_N - 1)) begin
                    j_reg <= '0;
                    i_reg <= i_reg + I_W'(1);
                end else begin
                    j_reg <= j_reg + J_W'(1);
                end
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_data  = out_data_reg;
    assign obusy         = obusy_reg;
    assign odone         = odone_reg;
    assign osat          = osat_reg;
endmodule

// File: tb/tb_gemm_stream_engine.sv
// Self-checking bench for gemm_stream_engine: directed and random jobs
// compared element by element against a plain-arithmetic GEMM model.
module tb_gemm_stream_engine;
    localparam int DW = 16;
    localparam int FB = 8;
    localparam int M  = 4;
    localparam int N  = 4;
    localparam int K  = 4;
    localparam int AW = 40;
    localparam int NA = M * K;
    localparam int NB = K * N;
    localparam int NC = M * N;

    logic iclk   = 1'b0;
    logic irst_n = 1'b0;
    logic istart = 1'b0;
    logic signed [DW-1:0] alpha = '0;
    logic signed [DW-1:0] beta  = '0;
    logic obusy, odone, osat;

    gemm_stream_engine_if #(.DATA_WIDTH(DW)) bus ();

    gemm_stream_engine #(
        .DATA_WIDTH (DW),
        .FRAC_BITS  (FB),
        .DIM_M      (M),
        .DIM_N      (N),
        .DIM_K      (K),
        .ACC_WIDTH  (AW)
    ) dut (
        .iclk   (iclk),
        .irst_n (irst_n),
        .istart (istart),
        .alpha  (alpha),
        .beta   (beta),
        .bus    (bus),
        .obusy  (obusy),
        .odone  (odone),
        .osat   (osat)
    );

    always #5 iclk = ~iclk;

    int tests    = 0;
    int failures = 0;
    int a_w [NA];
    int b_w [NB];
    int c_w [NC];
    int exp_q [$];
    bit exp_sat;
    int hs_cnt = 0;

    task automatic check(input string name, input longint got, input longint want);
        tests++;
        if (got != want) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic timeout(input string name);
        tests++;
        failures++;
        $display("[TB] FAIL %s: timeout waiting on DUT", name);
    endtask

    // Reference GEMM straight from the arithmetic definition
    task automatic model_job(input int al, input int be);
        longint acc, dot, t1, t2, s;
        exp_sat = 1'b0;
        for (int i = 0; i < M; i++) begin
            for (int j = 0; j < N; j++) begin
                acc = 0;
                for (int k = 0; k < K; k++) begin
                    acc += longint'(a_w[i*K+k]) * longint'(b_w[k*N+j]);
                end
                dot = acc >>> FB;
                t1  = (longint'(al) * dot) >>> FB;
                t2  = (longint'(be) * longint'(c_w[i*N+j])) >>> FB;
                s   = t1 + t2;
                if (s > 32767) begin
                    s = 32767;
                    exp_sat = 1'b1;
                end else if (s < -32768) begin
                    s = -32768;
                    exp_sat = 1'b1;
                end
                exp_q.push_back(int'(s));
            end
        end
    endtask

    task automatic set_identity();
        for (int r = 0; r < M; r++)
            for (int c = 0; c < K; c++)
                a_w[r*K+c] = (r == c) ? 256 : 0;
        for (int n = 0; n < NB; n++) b_w[n] = 256 * (n + 1);
        for (int n = 0; n < NC; n++) c_w[n] = 0;
    endtask

    task automatic fill_random(input int lo, input int hi);
        for (int n = 0; n < NA; n++) a_w[n] = int'($urandom_range(0, hi - lo)) + lo;
        for (int n = 0; n < NB; n++) b_w[n] = int'($urandom_range(0, hi - lo)) + lo;
        for (int n = 0; n < NC; n++) c_w[n] = int'($urandom_range(0, hi - lo)) + lo;
    endtask

    // Begins and ends at posedge+1
    task automatic start_job(input int al, input int be);
        model_job(al, be);
        hs_cnt = 0;
        alpha  = DW'(al);
        beta   = DW'(be);
        istart = 1'b1;
        @(posedge iclk); #1;
        istart = 1'b0;
        @(negedge iclk);
        check("obusy_after_start", obusy, 1);
        check("osat_cleared_on_start", osat, 0);
        check("in_ready_in_load", bus.in_ready, 1);
        @(posedge iclk); #1;
    endtask

    task automatic load_words(input bit gaps, input bit glitch);
        int words [$];
        int cyc;
        bit acc_ok;
        for (int n = 0; n < NA; n++) words.push_back(a_w[n]);
        for (int n = 0; n < NB; n++) words.push_back(b_w[n]);
        for (int n = 0; n < NC; n++) words.push_back(c_w[n]);
        for (int n = 0; n < words.size(); n++) begin
            if (gaps && n > 0 && n % 5 == 0) begin
                bus.in_valid = 1'b0;
                repeat (3) @(posedge iclk);
                #1;
            end
            bus.in_valid = 1'b1;
            bus.in_data  = DW'(words[n]);
            if (glitch && n == NA + 3) begin
                istart = 1'b1;
                alpha  = 16'sd77;
            end
            acc_ok = 1'b0;
            cyc    = 0;
            while (!acc_ok) begin
                @(negedge iclk);
                acc_ok = bus.in_ready;
                @(posedge iclk); #1;
                istart = 1'b0;
                cyc++;
                if (cyc > 100) begin
                    timeout("load_word");
                    bus.in_valid = 1'b0;
                    return;
                end
            end
        end
        bus.in_valid = 1'b0;
        if (glitch) begin
            istart = 1'b1;
            alpha  = 16'sd99;
            @(posedge iclk); #1;
            istart = 1'b0;
            @(negedge iclk);
            check("obusy_after_ignored_start", obusy, 1);
            @(posedge iclk); #1;
        end
    endtask

    // mode 0: always ready; 1: 5-cycle stall on element 6; 2: random ready
    task automatic drain(input int mode);
        int cyc = 0;
        int w;
        bit stalled = 1'b0;
        bus.out_ready = 1'b1;
        while (hs_cnt < NC) begin
            if (mode == 1 && hs_cnt == 6 && !stalled) begin
                bus.out_ready = 1'b0;
                w = 0;
                while (!bus.out_valid && w < 100) begin
                    @(negedge iclk);
                    w++;
                end
                if (w >= 100) timeout("stall_wait_valid");
                repeat (5) @(posedge iclk);
                #1;
                bus.out_ready = 1'b1;
                stalled = 1'b1;
            end else if (mode == 2) begin
                bus.out_ready = ($urandom_range(0, 3) != 0);
            end
            @(posedge iclk); #1;
            cyc++;
            if (cyc > 2000) begin
                timeout("drain");
                break;
            end
        end
        bus.out_ready = 1'b1;
        @(negedge iclk);
        check("osat_job", osat, exp_sat);
        check("obusy_after_done", obusy, 0);
        check("all_outputs_seen", exp_q.size(), 0);
        @(posedge iclk); #1;
    endtask

    // Compare process: output values, stall stability, odone timing
    initial begin : compare_proc
        bit odone_due  = 1'b0;
        bit prev_stall = 1'b0;
        logic signed [DW-1:0] prev_data = '0;
        int e;
        forever begin
            @(negedge iclk);
            if (!irst_n) begin
                odone_due  = 1'b0;
                prev_stall = 1'b0;
            end else begin
                if (odone_due || odone) check("odone_pulse", odone, odone_due);
                odone_due = 1'b0;
                if (prev_stall) begin
                    check("stall_valid_held", bus.out_valid, 1);
                    check("stall_data_stable", bus.out_data, prev_data);
                end
                if (bus.out_valid) check("in_ready_low_in_out", bus.in_ready, 0);
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        failures++;
                        $display("[TB] FAIL unexpected_output: got %0d, expected no output", bus.out_data);
                    end else begin
                        e = exp_q.pop_front();
                        $display("[TB] out r[%0d] = %0d (model %0d)", hs_cnt, bus.out_data, e);
                        check($sformatf("r[%0d]", hs_cnt), bus.out_data, e);
                    end
                    hs_cnt++;
                    if (hs_cnt == NC) odone_due = 1'b1;
                end
                prev_stall = bus.out_valid && !bus.out_ready;
                prev_data  = bus.out_data;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, bus.out_valid, 0);
        check({tag, "_out_data"}, bus.out_data, 0);
        check({tag, "_in_ready"}, bus.in_ready, 0);
        check({tag, "_obusy"}, obusy, 0);
        check({tag, "_odone"}, odone, 0);
        check({tag, "_osat"}, osat, 0);
    endtask

    initial begin : main
        int cyc;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;

        irst_n = 1'b0;
        repeat (3) @(posedge iclk);
        @(negedge iclk);
        check_reset_outputs("reset");
        @(posedge iclk); #1;
        irst_n = 1'b1;

        // Identity: outputs reproduce B
        set_identity();
        start_job(256, 0);
        check("model_pin_identity_first", exp_q[0], 256);
        check("model_pin_identity_last", exp_q[NC-1], 4096);
        load_words(0, 0);
        drain(0);

        // C-only path
        fill_random(-2000, 2000);
        for (int n = 0; n < NC; n++) c_w[n] = 256;
        start_job(0, 512);
        check("model_pin_c_only", exp_q[5], 512);
        load_words(0, 0);
        drain(0);

        // Negative identity
        for (int r = 0; r < M; r++)
            for (int c = 0; c < K; c++)
                a_w[r*K+c] = (r == c) ? -256 : 0;
        for (int n = 0; n < NB; n++) b_w[n] = 256;
        for (int n = 0; n < NC; n++) c_w[n] = 0;
        start_job(256, 0);
        check("model_pin_neg", exp_q[0], -256);
        load_words(0, 0);
        drain(0);

        // Saturation, both signs
        for (int n = 0; n < NA; n++) a_w[n] = 32512;
        for (int n = 0; n < NB; n++) b_w[n] = 32512;
        start_job(256, 0);
        check("model_pin_sat_pos", exp_q[0], 32767);
        load_words(0, 0);
        drain(0);
        for (int n = 0; n < NB; n++) b_w[n] = -32512;
        start_job(256, 0);
        check("model_pin_sat_neg", exp_q[0], -32768);
        load_words(0, 0);
        drain(0);

        // Identity with input gaps and an output stall
        set_identity();
        start_job(256, 0);
        load_words(1, 0);
        drain(1);

        // Identity with ignored starts during LOAD_B and MAC
        start_job(256, 0);
        load_words(0, 1);
        drain(0);

        // Reset during MAC of element 3 of a saturating job
        for (int n = 0; n < NA; n++) a_w[n] = 32512;
        for (int n = 0; n < NB; n++) b_w[n] = 32512;
        for (int n = 0; n < NC; n++) c_w[n] = 0;
        start_job(256, 0);
        load_words(0, 0);
        bus.out_ready = 1'b1;
        cyc = 0;
        while (hs_cnt < 3 && cyc < 500) begin
            @(posedge iclk); #1;
            cyc++;
        end
        if (hs_cnt < 3) timeout("reset_wait_element3");
        @(posedge iclk); #1;
        check("osat_before_reset", osat, 1);
        irst_n = 1'b0;
        @(posedge iclk); #1;
        irst_n = 1'b1;
        @(negedge iclk);
        check_reset_outputs("midreset");
        exp_q.delete();
        repeat (3) @(posedge iclk);
        #1;
        check("idle_after_reset_in_ready", bus.in_ready, 0);

        set_identity();
        start_job(256, 0);
        load_words(0, 0);
        drain(0);

        // Random jobs with gaps and random backpressure
        for (int t = 0; t < 4; t++) begin
            if (t < 2) fill_random(-32768, 32767);
            else       fill_random(-3000, 3000);
            start_job(int'($urandom_range(0, 65535)) - 32768,
                      int'($urandom_range(0, 65535)) - 32768);
            load_words(1, 0);
            drain(2);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule

// File: doc/gemm_stream_engine.md
Name: gemm_stream_engine

Overview:
Parametrised fixed-point GEMM engine computing R = alpha*(A x B) + beta*C for A (MxK), B (KxN) and C (MxN).
- Operands are loaded over a single valid/ready input stream into internal buffers.
- One multiply-accumulate (MAC) is performed per cycle.
- Each result element is emitted on a valid/ready output stream with backpressure.
- Successor to gemm_top: replaces real-typed matrix ports with a synthesisable signed Q-format datapath and arbitrary M/N/K.

Parameters:
DATA_WIDTH, 16, signed operand/result width (two's complement, Q format)
FRAC_BITS, 8, fractional bits of every operand, alpha, beta and result
DIM_M, 4, rows of A, C and R
DIM_N, 4, columns of B, C and R
DIM_K, 4, columns of A and rows of B
ACC_WIDTH, 40, dot-product accumulator width (must be >= 2*DATA_WIDTH + clog2(DIM_K))

Ports:
iclk  in  1  clock, all logic on rising edge
irst_n  in  1  synchronous active-low reset
istart  in  1  start pulse; honoured only in IDLE
alpha  in  DATA_WIDTH  signed Q scale for A x B; sampled when istart is accepted
beta  in  DATA_WIDTH  signed Q scale for C; sampled when istart is accepted
in_valid  in  1  input word valid
in_data  in  DATA_WIDTH  operand word
in_ready  out  1  engine accepts in_data this cycle
out_valid  out  1  out_data holds a result element
out_data  out  DATA_WIDTH  result element R[i][j]
out_ready  in  1  consumer accepts out_data
obusy  out  1  high from istart acceptance until odone
odone  out  1  one-cycle pulse after the last output handshake
osat  out  1  sticky flag: any result saturated in the current job

Behaviour:
- Reset (irst_n=0 at a clock edge):
  - State returns to IDLE.
  - in_ready, out_valid, out_data, obusy, odone and osat all go to 0.
  - Buffer contents are left undefined and are never read before being reloaded.
  - Reset has priority over every other event, including mid-load, mid-compute and an output stalled on out_ready=0.
- States and transitions:
  - IDLE: on istart -> LOAD_A; latch alpha/beta, set obusy, clear osat.
  - LOAD_A: in_ready=1; accept DIM_M*DIM_K words row-major -> LOAD_B.
  - LOAD_B: in_ready=1; accept DIM_K*DIM_N words row-major -> LOAD_C.
  - LOAD_C: in_ready=1; accept DIM_M*DIM_N words row-major -> MAC.
  - MAC: DIM_K cycles, acc += A[i][k]*B[k][j]; acc cleared on the first k -> SCALE.
  - SCALE: 1 cycle; compute R[i][j] into the out_data register, set out_valid -> OUT.
  - OUT: hold out_data stable while out_ready=0. On handshake: drop out_valid and advance (i,j) row-major -> MAC; after the last element -> IDLE with an odone pulse and obusy low.
- Input handshake:
  - A word transfers only when in_valid && in_ready.
  - in_valid gaps stall the load without loss.
  - in_ready=0 outside the LOAD states.
- Start and re-start:
  - istart is ignored while obusy=1.
  - odone and a new istart in the same cycle: istart is accepted on the next cycle (IDLE only).
- Latency and throughput:
  - Per element: DIM_K+1 cycles from MAC entry to out_valid, plus any stall.
  - With out_ready held at 1: one element every DIM_K+2 cycles.
- Arithmetic:
  - Products are full 2*DATA_WIDTH signed and sign-extended into ACC_WIDTH; the accumulator never overflows for legal parameters.
  - dot = acc >>> FRAC_BITS (arithmetic shift, truncation toward -inf).
  - t1 = (alpha*dot) >>> FRAC_BITS
  - t2 = (beta*C[i][j]) >>> FRAC_BITS
  - sum = t1 + t2, computed at ACC_WIDTH+DATA_WIDTH+1 bits.
  - Saturate sum to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]; on saturation set osat, which holds until the next accepted istart.
- Output order: R[0][0]..R[0][N-1], R[1][0], ..., exactly DIM_M*DIM_N handshakes per job.

Decomposition:
- Package gemm_pkg:
  - state enum (IDLE, LOAD_A, LOAD_B, LOAD_C, MAC, SCALE, OUT);
  - localparams for buffer depths (DIM_M*DIM_K, DIM_K*DIM_N, DIM_M*DIM_N) and index widths via clog2;
  - saturation function sat_to_data.
- Sub-module gemm_mac: signed multiplier plus accumulator with clear/enable, parametrised by DATA_WIDTH and ACC_WIDTH.
- Top level holds the FSM, the three operand buffers, the index counters and the scale/saturate stage.

Test Plan:
- Identity: A=I (diagonal 256), B[r][c]=256*(4r+c+1), C=0, alpha=256, beta=0 -> 16 outputs equal B row-major (256..4096); odone one cycle after the 16th handshake; osat=0.
- C-only path: alpha=0, beta=512 (2.0), C all 256 -> all outputs 512; negative case with A=-I (-256), B all 256, alpha=256, beta=0 -> all outputs -256.
- Saturation: A and B all 32512 (127.0), alpha=256, beta=0 -> all outputs 32767 and osat=1; with all B=-32512 -> all outputs -32768.
- Backpressure and gaps: deassert in_valid for 3 cycles every 5 words during load; drop out_ready for 5 cycles at element 6 -> out_data stable while stalled, results bit-identical to the identity run, order preserved.
- Ignored start: pulse istart during LOAD_B and during MAC -> no effect; the job completes normally with exactly 16 outputs.
- Reset mid-operation: irst_n=0 for 1 cycle during MAC of element 3 -> next cycle all outputs 0 and state IDLE; a fresh istart plus full reload reproduces the identity results.
